// File: rtl/key_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : key_strobe
//  Purpose  : Key conditioning stage. Synchronises a raw asynchronous key
//             line, debounces it, and emits clean single-cycle strobes: one
//             per press, plus optional auto-repeat strobes while held.
//  Ports    : CLKB  - clock, all logic on the rising edge
//             rst_n - synchronous active-low reset
//             en    - strobe enable; low forces sig=0 and the FSM to IDLE
//             btn   - raw asynchronous key input
//             sig   - registered single-cycle strobe
//             level - registered debounced key level
//             held  - registered, high while the repeat FSM is in REPEAT
//  Revision : 1.0 - initial release
// ============================================================================
module key_strobe #(
    parameter int STABLE        = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic CLKB,
    input  logic rst_n,
    input  logic en,
    input  logic btn,
    output logic sig,
    output logic level,
    output logic held
);

    // Counter widths: db_cnt holds STABLE-1, rp_cnt holds max(delay,period)-1.
    localparam int c_DB_W   = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int c_RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RP_W   = (c_RP_MAX > 1) ? $clog2(c_RP_MAX) : 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(STABLE - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
    localparam logic [c_DB_W-1:0] c_DB_ZERO = '0;

    localparam logic [c_RP_W-1:0] c_RP_DLY_LAST = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_RP_PER_LAST = c_RP_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RP_W-1:0] c_RP_ONE      = c_RP_W'(1);
    localparam logic [c_RP_W-1:0] c_RP_ZERO     = '0;

    localparam logic c_RPT_ON = (REPEAT_EN != 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    logic              r_s1;
    logic              r_btn_s;
    logic              r_level;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [1:0]        r_state;
    logic [c_RP_W-1:0] r_rp_cnt;
    logic              r_sig;
    logic              r_held;

    logic              w_rise;
    logic              w_press;
    logic [1:0]        w_nstate;
    logic [c_RP_W-1:0] w_nrp;
    logic              w_rp_strobe;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; nothing else looks at btn.
    // ------------------------------------------------------------------
    always_ff @(posedge CLKB) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_s1    <= btn;
            r_btn_s <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive mismatching samples, accept the new
    // level on the STABLE-th one. Any agreeing sample restarts the count,
    // so short glitches never reach the terminal value.
    // ------------------------------------------------------------------
    always_ff @(posedge CLKB) begin
        if (!rst_n) begin
            r_level  <= 1'b0;
            r_db_cnt <= c_DB_ZERO;
        end else if (r_btn_s == r_level) begin
            r_db_cnt <= c_DB_ZERO;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_level  <= r_btn_s;
            r_db_cnt <= c_DB_ZERO;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_ONE;
        end
    end

    // Level is about to go 0->1 on this edge.
    assign w_rise  = (r_btn_s != r_level) && (r_db_cnt == c_DB_LAST) && r_btn_s;
    assign w_press = w_rise && en;

    // ------------------------------------------------------------------
    // Repeat FSM. A press takes priority over the abort check: a press
    // only happens while level is low, which would otherwise abort, so
    // a very fast re-press still restarts the repeat sequence.
    // ------------------------------------------------------------------
    always_comb begin
        w_nstate    = r_state;
        w_nrp       = r_rp_cnt;
        w_rp_strobe = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_press && c_RPT_ON) begin
                    w_nstate = c_DELAY;
                    w_nrp    = c_RP_ZERO;
                end
            end
            c_DELAY: begin
                if (w_press && c_RPT_ON) begin
                    w_nstate = c_DELAY;
                    w_nrp    = c_RP_ZERO;
                end else if (!en || !r_level) begin
                    w_nstate = c_IDLE;
                    w_nrp    = c_RP_ZERO;
                end else if (r_rp_cnt == c_RP_DLY_LAST) begin
                    w_rp_strobe = 1'b1;
                    w_nstate    = c_REPEAT;
                    w_nrp       = c_RP_ZERO;
                end else begin
                    w_nrp = r_rp_cnt + c_RP_ONE;
                end
            end
            c_REPEAT: begin
                if (w_press && c_RPT_ON) begin
                    w_nstate = c_DELAY;
                    w_nrp    = c_RP_ZERO;
                end else if (!en || !r_level) begin
                    w_nstate = c_IDLE;
                    w_nrp    = c_RP_ZERO;
                end else if (r_rp_cnt == c_RP_PER_LAST) begin
                    w_rp_strobe = 1'b1;
                    w_nrp       = c_RP_ZERO;
                end else begin
                    w_nrp = r_rp_cnt + c_RP_ONE;
                end
            end
            default: begin
                w_nstate = c_IDLE;
                w_nrp    = c_RP_ZERO;
            end
        endcase
    end

    always_ff @(posedge CLKB) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_rp_cnt <= c_RP_ZERO;
            r_sig    <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_rp_cnt <= w_nrp;
            // Repeat strobes only occur with en high (en low aborts first).
            r_sig    <= w_press || w_rp_strobe;
            r_held   <= (w_nstate == c_REPEAT);
        end
    end

    assign sig   = r_sig;
    assign level = r_level;
    assign held  = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_strobe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_strobe
//  Purpose  : Directed self-checking bench for key_strobe. A second instance
//             with auto-repeat disabled shares the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_key_strobe;

    logic CLKB;
    logic rst_n;
    logic en;
    logic btn;
    logic sig;
    logic level;
    logic held;
    logic sig2;
    logic level2;
    logic held2;

    int n_checks;
    int n_err;
    int dbl;
    logic prev_sig;
    logic prev_sig2;

    key_strobe u_dut (
        .CLKB  (CLKB),
        .rst_n (rst_n),
        .en    (en),
        .btn   (btn),
        .sig   (sig),
        .level (level),
        .held  (held)
    );

    key_strobe #(.REPEAT_EN(0)) u_dut_norpt (
        .CLKB  (CLKB),
        .rst_n (rst_n),
        .en    (en),
        .btn   (btn),
        .sig   (sig2),
        .level (level2),
        .held  (held2)
    );

    initial CLKB = 1'b0;
    always #5 CLKB = ~CLKB;

    // Back-to-back strobe watch on both instances.
    initial begin
        dbl       = 0;
        prev_sig  = 1'b0;
        prev_sig2 = 1'b0;
        forever begin
            @(negedge CLKB);
            if (sig === 1'b1 && prev_sig === 1'b1)  dbl = dbl + 1;
            if (sig2 === 1'b1 && prev_sig2 === 1'b1) dbl = dbl + 1;
            prev_sig  = sig;
            prev_sig2 = sig2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles (negedge samples) until the first sig strobe; 0 if none in 20.
    task automatic wait_strobe(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLKB);
            if (sig === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int cnt1, cnt2, bad_sig, bad_held, bad_lvl, bad_sig2, bad_held2;
    logic e_sig, e_held, e_lvl;

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        btn      = 1'b1;

        // ---------------- reset with the key already down ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge CLKB);
            check("rst_sig",   {31'd0, sig},   32'd0);
            check("rst_level", {31'd0, level}, 32'd0);
            check("rst_held",  {31'd0, held},  32'd0);
        end
        rst_n = 1'b1;
        wait_strobe(lat);
        check("press_latency", lat, 32'd6);
        check("press_level",   {31'd0, level}, 32'd1);
        check("press_sig2",    {31'd0, sig2},  32'd1);

        // ---------------- auto-repeat, then release at offset 100 ----------
        cnt1 = 0; bad_sig = 0; bad_held = 0; bad_lvl = 0; bad_sig2 = 0; bad_held2 = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge CLKB);
            e_sig  = (i >= 16) && (((i - 16) % 8) == 0) && (i <= 106);
            e_held = (i >= 16) && (i <= 106);
            e_lvl  = (i <= 105);
            if (sig === 1'b1)   cnt1 = cnt1 + 1;
            if (sig !== e_sig)   bad_sig   = bad_sig + 1;
            if (held !== e_held) bad_held  = bad_held + 1;
            if (level !== e_lvl || level2 !== e_lvl) bad_lvl = bad_lvl + 1;
            if (sig2 !== 1'b0)   bad_sig2  = bad_sig2 + 1;
            if (held2 !== 1'b0)  bad_held2 = bad_held2 + 1;
            if (i == 16) check("held_at_P16", {31'd0, held}, 32'd1);
            if (i == 100) btn = 1'b0;
        end
        check("rpt_strobe_count", cnt1, 32'd12);
        check("rpt_sig_pattern",  bad_sig, 32'd0);
        check("rpt_held_pattern", bad_held, 32'd0);
        check("rpt_level_pattern", bad_lvl, 32'd0);
        check("norpt_no_strobes", bad_sig2, 32'd0);
        check("norpt_held_low",   bad_held2, 32'd0);

        // ---------------- bounce rejection ----------------
        cnt1 = 0; bad_lvl = 0;
        for (int k = 0; k < 20; k++) begin
            btn = (((k / 2) % 2) == 0);
            @(negedge CLKB);
            if (sig === 1'b1 || sig2 === 1'b1) cnt1 = cnt1 + 1;
            if (level !== 1'b0) bad_lvl = bad_lvl + 1;
        end
        check("bounce_strobes", cnt1, 32'd0);
        check("bounce_level",   bad_lvl, 32'd0);
        btn = 1'b1;
        wait_strobe(lat);
        check("bounce_final_latency", lat, 32'd6);

        // ---------------- release during DELAY ----------------
        cnt1 = 0; bad_held = 0; bad_lvl = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLKB);
            if (sig === 1'b1 || sig2 === 1'b1) cnt1 = cnt1 + 1;
            if (held !== 1'b0) bad_held = bad_held + 1;
            if (level !== (i <= 13)) bad_lvl = bad_lvl + 1;
            if (i == 8) btn = 1'b0;
        end
        check("delay_abort_strobes", cnt1, 32'd0);
        check("delay_abort_held",    bad_held, 32'd0);
        check("delay_abort_level",   bad_lvl, 32'd0);

        // ---------------- enable gating ----------------
        en  = 1'b0;
        btn = 1'b1;
        cnt1 = 0; bad_held = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLKB);
            if (sig === 1'b1 || sig2 === 1'b1) cnt1 = cnt1 + 1;
        end
        check("en_off_level", {31'd0, level}, 32'd1);
        en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLKB);
            if (sig === 1'b1 || sig2 === 1'b1) cnt1 = cnt1 + 1;
            if (held !== 1'b0) bad_held = bad_held + 1;
        end
        btn = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLKB);
            if (sig === 1'b1 || sig2 === 1'b1) cnt1 = cnt1 + 1;
        end
        check("en_gate_strobes", cnt1, 32'd0);
        check("en_gate_held",    bad_held, 32'd0);
        check("en_release_level", {31'd0, level}, 32'd0);
        btn = 1'b1;
        wait_strobe(lat);
        check("en_repress_latency", lat, 32'd6);
        check("en_repress_sig2",    {31'd0, sig2}, 32'd1);

        // ---------------- reset while held ----------------
        for (int i = 1; i <= 20; i++) @(negedge CLKB);
        check("pre_reset_held", {31'd0, held}, 32'd1);
        rst_n = 1'b0;
        @(negedge CLKB);
        @(negedge CLKB);
        check("midrst_sig",   {31'd0, sig},   32'd0);
        check("midrst_level", {31'd0, level}, 32'd0);
        check("midrst_held",  {31'd0, held},  32'd0);
        rst_n = 1'b1;
        wait_strobe(lat);
        check("post_reset_latency", lat, 32'd6);

        check("no_back_to_back", dbl, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
